// File: rtl/gate_reduce_seq_if.sv
// Operand/op/mode request channel plus result channel of the reduction-gate unit.
// The master modport drives requests and takes results; the slave modport is the unit.
interface gate_reduce_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_y;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_op, in_mode, out_ready,
    input  in_ready, out_valid, out_y, out_err
  );

  modport slave (
    input  in_valid, in_data, in_op, in_mode, out_ready,
    output in_ready, out_valid, out_y, out_err
  );
endinterface

// File: rtl/gate_reduce_seq.sv
// AND/NAND/OR/NOR/XOR/XNOR reduction of a WIDTH-bit operand, parallel or bit-serial (LSB first).
// Result 1 edge (parallel/illegal) or WIDTH edges (serial) after accept; held until out_ready, one op in flight.
module gate_reduce_seq #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  gate_reduce_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERIAL = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             acc_q, acc_d;
  logic             oneshot_q, oneshot_d;
  logic             y_q, y_d;
  logic             err_q, err_d;
  logic             acc_n, red, op_bad, in_bad;

  assign op_bad = op_q[2] & op_q[1];
  assign in_bad = bus.in_op[2] & bus.in_op[1];

  // op[2:1] selects the base gate; op[0] marks the inverted variant.
  always_comb begin
    acc_n = acc_q ^ sreg_q[0];
    red   = ^sreg_q;
    case (op_q[2:1])
      2'b00: begin
        acc_n = acc_q & sreg_q[0];
        red   = &sreg_q;
      end
      2'b01: begin
        acc_n = acc_q | sreg_q[0];
        red   = |sreg_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    oneshot_d = oneshot_q;
    y_d       = y_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sreg_d    = bus.in_data;
          op_d      = bus.in_op;
          acc_d     = (bus.in_op[2:1] == 2'b00);
          cnt_d     = '0;
          // Parallel and illegal ops spend exactly one SERIAL cycle, matching WIDTH=1 serial timing.
          oneshot_d = ~bus.in_mode | in_bad;
          state_d   = SERIAL;
        end
      end
      SERIAL: begin
        if (oneshot_q) begin
          y_d     = ~op_bad & (red ^ op_q[0]);
          err_d   = op_bad;
          state_d = HOLD;
        end else begin
          acc_d  = acc_n;
          sreg_d = sreg_q >> 1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            y_d     = acc_n ^ op_q[0];
            err_d   = 1'b0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= 1'b0;
      oneshot_q <= 1'b0;
      y_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      oneshot_q <= oneshot_d;
      y_q       <= y_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_y     = y_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_gate_reduce_seq.sv
// Bench for gate_reduce_seq: WIDTH=8 and WIDTH=1 instances, cycle-level reference model plus directed vectors.
// Model tracks busy cycles and computes results from the count of ones in the operand.
module tb_gate_reduce_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_reduce_seq_if #(.WIDTH(8)) b0();
  gate_reduce_seq_if #(.WIDTH(1)) b1();

  gate_reduce_seq #(.WIDTH(8)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  gate_reduce_seq #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Uniform views of both instances
  logic       iv[2], ir[2], md[2], ov[2], oy[2], oe[2], ordy[2];
  logic [2:0] iop[2];
  logic [7:0] idat[2];
  always_comb begin
    iv[0] = b0.in_valid;  iv[1] = b1.in_valid;
    ir[0] = b0.in_ready;  ir[1] = b1.in_ready;
    md[0] = b0.in_mode;   md[1] = b1.in_mode;
    ov[0] = b0.out_valid; ov[1] = b1.out_valid;
    oy[0] = b0.out_y;     oy[1] = b1.out_y;
    oe[0] = b0.out_err;   oe[1] = b1.out_err;
    ordy[0] = b0.out_ready; ordy[1] = b1.out_ready;
    iop[0] = b0.in_op;    iop[1] = b1.in_op;
    idat[0] = b0.in_data; idat[1] = {7'b0, b1.in_data};
  end

  // Returns {err, y}
  function automatic logic [1:0] ref_res(int w, logic [2:0] op, logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    case (op)
      3'd0: return {1'b0, ones == w};
      3'd1: return {1'b0, ones != w};
      3'd2: return {1'b0, ones != 0};
      3'd3: return {1'b0, ones == 0};
      3'd4: return {1'b0, (ones % 2) == 1};
      3'd5: return {1'b0, (ones % 2) == 0};
      default: return 2'b10;
    endcase
  endfunction

  bit   m_hold[2];
  int   m_left[2];
  logic m_y[2], m_err[2];
  int   m_hs[2], d_hs[2];
  bit   started = 0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = 0; m_left[k] = 0; m_y[k] = 0; m_err[k] = 0; m_hs[k] = 0; d_hs[k] = 0;
    end
  end

  always @(posedge clk) begin
    logic [1:0] r;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_hold[k] = 0;
        m_left[k] = 0;
      end else if (m_hold[k]) begin
        if (ordy[k]) begin
          m_hold[k] = 0;
          m_hs[k]++;
        end
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) m_hold[k] = 1;
      end else if (iv[k]) begin
        r = ref_res(k == 1 ? 1 : 8, iop[k], idat[k]);
        m_y[k]   = r[0];
        m_err[k] = r[1];
        m_left[k] = (md[k] && !r[1]) ? (k == 1 ? 1 : 8) : 1;
      end
    end
    if (rst) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc_in_ready[%0d]", k), 32'(ir[k]), 32'(!m_hold[k] && m_left[k] == 0));
        chk($sformatf("cyc_out_valid[%0d]", k), 32'(ov[k]), 32'(m_hold[k]));
        if (m_hold[k]) begin
          chk($sformatf("cyc_out_y[%0d]", k), 32'(oy[k]), 32'(m_y[k]));
          chk($sformatf("cyc_out_err[%0d]", k), 32'(oe[k]), 32'(m_err[k]));
        end
        if (!rst && ov[k] === 1'b1 && ordy[k]) d_hs[k]++;
      end
    end
  end

  task automatic drive(int k, logic v, logic [2:0] op, logic [7:0] d, logic mode);
    if (k == 0) begin
      b0.in_valid = v; b0.in_op = op; b0.in_data = d; b0.in_mode = mode;
    end else begin
      b1.in_valid = v; b1.in_op = op; b1.in_data = d[0]; b1.in_mode = mode;
    end
  endtask

  task automatic set_ordy(int k, logic r);
    if (k == 0) b0.out_ready = r;
    else        b1.out_ready = r;
  endtask

  task automatic run_op(int k, logic [2:0] op, logic [7:0] d, logic mode,
                        int exp_lat, logic exp_y, logic exp_err, string nm);
    int n;
    @(posedge clk); #1;
    chk({nm, "_in_ready"}, 32'(ir[k]), 32'd1);
    drive(k, 1'b1, op, d, mode);
    @(posedge clk); #1;
    drive(k, 1'b0, 3'd0, 8'h00, 1'b0);
    n = 0;
    while (ov[k] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "_out_y"}, 32'(oy[k]), 32'(exp_y));
    chk({nm, "_out_err"}, 32'(oe[k]), 32'(exp_err));
  endtask

  task automatic handoff(int k, string nm);
    @(posedge clk); #1;
    set_ordy(k, 1'b1);
    @(posedge clk); #1;
    set_ordy(k, 1'b0);
    chk({nm, "_ho_out_valid"}, 32'(ov[k]), 32'd0);
    chk({nm, "_ho_in_ready"}, 32'(ir[k]), 32'd1);
  endtask

  typedef struct { logic [2:0] op; logic d; logic mode; } b2b_t;
  b2b_t b2b[5] = '{'{3'd0, 1'b1, 1'b1}, '{3'd5, 1'b1, 1'b0}, '{3'd3, 1'b0, 1'b1},
                   '{3'd6, 1'b1, 1'b1}, '{3'd2, 1'b0, 1'b0}};

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 3'd0, 8'h00, 1'b0);
    drive(1, 1'b0, 3'd0, 8'h00, 1'b0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(b0.out_valid), 32'd0);
    chk("reset_out_y", 32'(b0.out_y), 32'd0);
    chk("reset_out_err", 32'(b0.out_err), 32'd0);
    chk("reset_in_ready", 32'(b0.in_ready), 32'd1);
    chk("reset_w1_out_valid", 32'(b1.out_valid), 32'd0);

    run_op(0, 3'd1, 8'hFF, 1'b0, 1, 1'b0, 1'b0, "par_nand_ff");
    handoff(0, "par_nand_ff");

    run_op(0, 3'd4, 8'b1011_0001, 1'b1, 8, 1'b0, 1'b0, "ser_xor");
    handoff(0, "ser_xor");
    run_op(0, 3'd5, 8'b1011_0001, 1'b1, 8, 1'b1, 1'b0, "ser_xnor");
    handoff(0, "ser_xnor");

    run_op(0, 3'd2, 8'h00, 1'b0, 1, 1'b0, 1'b0, "par_or_zero");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(b0.out_valid), 32'd1);
      chk("stall_out_y", 32'(b0.out_y), 32'd0);
      chk("stall_in_ready", 32'(b0.in_ready), 32'd0);
    end
    handoff(0, "par_or_zero");

    // Serial AND aborted by reset sampled at accept edge + 3
    @(posedge clk); #1;
    drive(0, 1'b1, 3'd0, 8'hFF, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'd0, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 32'(b0.out_valid), 32'd0);
    chk("abort_in_ready", 32'(b0.in_ready), 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("abort_no_result", 32'(b0.out_valid), 32'd0);
    end
    run_op(0, 3'd0, 8'hFF, 1'b1, 8, 1'b1, 1'b0, "ser_and_ff");
    handoff(0, "ser_and_ff");

    run_op(0, 3'd7, 8'h5A, 1'b1, 1, 1'b0, 1'b1, "illegal_ser");
    handoff(0, "illegal_ser");
    run_op(0, 3'd6, 8'h00, 1'b0, 1, 1'b0, 1'b1, "illegal_par");
    handoff(0, "illegal_par");
    run_op(0, 3'd2, 8'h80, 1'b1, 8, 1'b1, 1'b0, "ser_or_msb");
    handoff(0, "ser_or_msb");
    run_op(0, 3'd1, 8'h7F, 1'b1, 8, 1'b1, 1'b0, "ser_nand_7f");
    handoff(0, "ser_nand_7f");
    run_op(0, 3'd0, 8'hFE, 1'b0, 1, 1'b0, 1'b0, "par_and_fe");
    handoff(0, "par_and_fe");
    run_op(0, 3'd3, 8'h00, 1'b0, 1, 1'b1, 1'b0, "par_nor_zero");
    handoff(0, "par_nor_zero");

    run_op(1, 3'd3, 8'h01, 1'b1, 1, 1'b0, 1'b0, "w1_ser_nor");
    handoff(1, "w1_ser_nor");

    // Back-to-back stream on WIDTH=1 with the consumer always ready
    set_ordy(1, 1'b1);
    foreach (b2b[i]) begin
      int n;
      @(posedge clk); #1;
      drive(1, 1'b1, b2b[i].op, {7'b0, b2b[i].d}, b2b[i].mode);
      n = 0;
      while (ir[1] !== 1'b1 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_wait_bound", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      drive(1, 1'b0, 3'd0, 8'h00, 1'b0);
    end
    repeat (8) @(posedge clk);
    #1 set_ordy(1, 1'b0);
    @(negedge clk);
    chk("w1_result_count", 32'(d_hs[1]), 32'd6);
    chk("w1_model_count", 32'(m_hs[1]), 32'd6);
    chk("w8_result_count", 32'(d_hs[0]), 32'(m_hs[0]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
